// File: rtl/herald_pkg.sv
// Shared types and pin/opcode field positions for the Herald pin command receiver.
package herald_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK_OP    = 2'd1,
        WAIT_DATA = 2'd2,
        ACK_DATA  = 2'd3
    } state_t;

    // Bidirectional pin assignments
    localparam int         STB_BIT     = 0;
    localparam int         ACK_BIT     = 1;
    localparam int         ERR_BIT     = 2;
    localparam logic [7:0] UIO_OE_MASK = 8'h06;

    // Opcode byte fields
    localparam int         WR_BIT      = 7;
    localparam int         ADDR_MSB    = 3;
    localparam logic [3:0] STATUS_ADDR = 4'hF;

    // True when addr selects one of the writable config registers
    function automatic logic addr_in_file(input logic [3:0] addr, input int nregs);
        return int'(addr) < nregs;
    endfunction

endpackage

// File: rtl/herald_pin_cmd_rx_if.sv
// Host-facing user pin bundle: host (master) drives ui_in/uio_in, device (slave) drives the rest.
interface herald_pin_cmd_rx_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/herald_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by synchronous reset.
module herald_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Shift the input through two flops to settle metastability
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/herald_pin_cmd_rx.sv
// Device-side responder for the host pin command protocol: four-phase STB/ACK
// handshake per byte, small config register file, read mux with status at 4'hF.
module herald_pin_cmd_rx
    import herald_pkg::*;
#(
    parameter int NREGS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    herald_pin_cmd_rx_if.slave   pins,
    input  logic [7:0]           status_i,
    output logic [8*NREGS-1:0]   regs_o
);
    localparam int             CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t          r_state;
    logic            r_ack;
    logic            r_err;
    logic            r_wr;
    logic [3:0]      r_addr;
    logic [7:0]      r_uo;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_regs [NREGS];

    logic            w_stb_s;
    logic [3:0]      w_op_addr;
    logic            w_op_wr;
    logic            w_op_ok;
    logic [7:0]      w_rdata;
    logic [7:0]      w_uio;
    logic            w_unused;

    herald_sync2 u_stb_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (pins.uio_in[STB_BIT]),
        .o_q     (w_stb_s)
    );

    assign w_op_addr = pins.ui_in[ADDR_MSB:0];
    assign w_op_wr   = pins.ui_in[WR_BIT];
    // Status is read-only, so a write to its address is flagged like any bad address
    assign w_op_ok   = addr_in_file(w_op_addr, NREGS) || ((w_op_addr == STATUS_ADDR) && !w_op_wr);
    assign w_unused  = ^{pins.uio_in[7:1], pins.ui_in[6:4]};

    // Read mux addressed directly by the incoming opcode byte
    always_comb begin
        w_rdata = '0;
        if (w_op_addr == STATUS_ADDR) begin
            w_rdata = status_i;
        end else begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                if (w_op_addr == 4'(k)) begin
                    w_rdata = r_regs[k];
                end
            end
        end
    end

    // Handshake FSM with registered ACK/ERR, read data and register file
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_uo    <= '0;
            r_cnt   <= '0;
            for (int unsigned k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (!ena) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    if (w_stb_s) begin
                        r_wr    <= w_op_wr;
                        r_addr  <= w_op_addr;
                        r_err   <= !w_op_ok;
                        if (!w_op_wr) begin
                            r_uo <= w_rdata;
                        end
                        r_ack   <= 1'b1;
                        r_state <= ACK_OP;
                    end
                end
                ACK_OP: begin
                    if (!w_stb_s) begin
                        r_ack   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= r_wr ? WAIT_DATA : IDLE;
                    end
                end
                WAIT_DATA: begin
                    if (w_stb_s) begin
                        for (int unsigned k = 0; k < NREGS; k++) begin
                            if (r_addr == 4'(k)) begin
                                r_regs[k] <= pins.ui_in;
                            end
                        end
                        r_ack   <= 1'b1;
                        r_state <= ACK_DATA;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ACK_DATA: begin
                    if (!w_stb_s) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Pack ACK/ERR into the bidirectional pin byte, all other bits low
    always_comb begin
        w_uio          = '0;
        w_uio[ACK_BIT] = r_ack;
        w_uio[ERR_BIT] = r_err;
    end

    assign pins.uio_out = w_uio;
    assign pins.uo_out  = r_uo;
    assign pins.uio_oe  = UIO_OE_MASK;

    for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
        assign regs_o[8*g +: 8] = r_regs[g];
    end
endmodule

// File: tb/tb_herald_pin_cmd_rx.sv
// Self-checking bench for herald_pin_cmd_rx: vector table driven through a
// host handshake task with a scoreboard queue, plus timeout/reset/ena sequences.
module tb_herald_pin_cmd_rx;
    import herald_pkg::*;

    localparam int NREGS   = 8;
    localparam int TIMEOUT = 255;

    typedef struct {
        logic [7:0] op;
        logic [7:0] data;
        logic [7:0] exp_uo;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] uo;
        logic       err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ena;
    logic [7:0]          status;
    logic [8*NREGS-1:0]  regs;

    int                  n_checks = 0;
    int                  n_errors = 0;
    logic [7:0]          model [NREGS];
    exp_t                sb [$];
    vec_t                vecs [13];

    herald_pin_cmd_rx_if bus ();

    herald_pin_cmd_rx #(.NREGS(NREGS), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .pins     (bus.slave),
        .status_i (status),
        .regs_o   (regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_packed();
        logic [63:0] p;
        p = '0;
        for (int k = 0; k < NREGS; k++) p[8*k +: 8] = model[k];
        return p;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < NREGS; k++) model[k] = 8'h00;
    endtask

    // One four-phase byte transfer; ACK must follow each STB edge within 4 cycles
    task automatic handshake(input logic [7:0] b);
        bit seen;
        bus.ui_in  = b;
        bus.uio_in = 8'b1010_1011;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.uio_out[ACK_BIT]) begin seen = 1'b1; break; end
        end
        check($sformatf("ack_rise_%02h", b), 64'(seen), 64'd1);
        bus.uio_in = 8'b1010_1010;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!bus.uio_out[ACK_BIT]) begin seen = 1'b1; break; end
        end
        check($sformatf("ack_fall_%02h", b), 64'(seen), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        //            op     data   exp_uo exp_err
        vecs[0]  = '{8'h83, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{8'h03, 8'h00, 8'hA5, 1'b0};
        vecs[2]  = '{8'h0F, 8'h00, 8'h3C, 1'b0};
        vecs[3]  = '{8'h89, 8'h77, 8'h3C, 1'b1};
        vecs[4]  = '{8'h03, 8'h00, 8'hA5, 1'b0};
        vecs[5]  = '{8'h80, 8'h11, 8'hA5, 1'b0};
        vecs[6]  = '{8'h87, 8'hFE, 8'hA5, 1'b0};
        vecs[7]  = '{8'h07, 8'h00, 8'hFE, 1'b0};
        vecs[8]  = '{8'h00, 8'h00, 8'h11, 1'b0};
        vecs[9]  = '{8'h08, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{8'h8F, 8'h55, 8'h00, 1'b1};
        vecs[11] = '{8'h7F, 8'h00, 8'h3C, 1'b0};
        vecs[12] = '{8'h05, 8'h00, 8'h00, 1'b0};

        clear_model();
        status     = 8'h3C;
        ena        = 1'b1;
        rst_n      = 1'b0;
        bus.ui_in  = 8'h83;
        bus.uio_in = 8'h01;

        // Reset held 5 cycles with STB high
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_uo_out",  64'(bus.uo_out),  64'h00);
        check("rst_uio_out", 64'(bus.uio_out), 64'h00);
        check("rst_uio_oe",  64'(bus.uio_oe),  64'h06);
        check("rst_regs",    64'(regs),        64'h0);
        check("rst_state",   64'(dut.r_state), 64'(IDLE));
        bus.uio_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven transactions through the scoreboard
        for (int i = 0; i < 13; i++) begin
            sb.push_back('{vecs[i].exp_uo, vecs[i].exp_err});
            handshake(vecs[i].op);
            if (vecs[i].op[7]) begin
                handshake(vecs[i].data);
                if (vecs[i].op[3:0] < 4'(NREGS)) model[vecs[i].op[3:0]] = vecs[i].data;
            end
            @(negedge clk);
            if (sb.size() == 0) begin
                check($sformatf("vec%0d_sb_empty", i), 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("vec%0d_uo", i),   64'(bus.uo_out),  64'(e.uo));
                check($sformatf("vec%0d_uio", i),  64'(bus.uio_out), 64'({e.err, 2'b00}));
                check($sformatf("vec%0d_regs", i), 64'(regs),        model_packed());
            end
        end

        // Timeout in WAIT_DATA: ERR only after TIMEOUT cycles, no write
        handshake(8'h81);
        repeat (TIMEOUT - 10) @(negedge clk);
        check("to_early_uio", 64'(bus.uio_out), 64'h00);
        repeat (15) @(negedge clk);
        check("to_uio",   64'(bus.uio_out), 64'h04);
        check("to_state", 64'(dut.r_state), 64'(IDLE));
        check("to_regs",  64'(regs),        model_packed());
        handshake(8'h81);
        handshake(8'h42);
        model[1] = 8'h42;
        @(negedge clk);
        check("to_retry_uio",  64'(bus.uio_out), 64'h00);
        check("to_retry_regs", 64'(regs),        model_packed());

        // Reset in WAIT_DATA
        handshake(8'h01);
        check("rd1_uo", 64'(bus.uo_out), 64'h42);
        handshake(8'h83);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        clear_model();
        check("abort_rst_uo",    64'(bus.uo_out),  64'h00);
        check("abort_rst_uio",   64'(bus.uio_out), 64'h00);
        check("abort_rst_regs",  64'(regs),        model_packed());
        check("abort_rst_state", 64'(dut.r_state), 64'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // ena low in WAIT_DATA drops the write but keeps regs and uo_out
        handshake(8'h82);
        handshake(8'h99);
        model[2] = 8'h99;
        handshake(8'h02);
        check("rd2_uo", 64'(bus.uo_out), 64'h99);
        handshake(8'h84);
        ena = 1'b0;
        @(negedge clk);
        check("abort_ena_state", 64'(dut.r_state), 64'(IDLE));
        check("abort_ena_uio",   64'(bus.uio_out), 64'h00);
        bus.ui_in  = 8'h12;
        bus.uio_in = 8'h01;
        repeat (4) @(negedge clk);
        bus.uio_in = 8'h00;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_ena_uo",    64'(bus.uo_out),  64'h99);
        check("abort_ena_regs",  64'(regs),        model_packed());
        check("abort_ena_idle",  64'(dut.r_state), 64'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
